// File: rtl/ecc_instr_pkg.sv
// ============================================================================
//  Module      : ecc_instr (package)
//  Description : Definitions shared by the ECC coprocessor datapath units:
//                the coprocessor operand width and the state encoding of the
//                sequential modular multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_instr;

    // Width of operands, modulus and results throughout the coprocessor.
    localparam int EccWidth = 64;

    // Modular multiplier control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage : ecc_instr

`default_nettype wire

// File: rtl/mul_modular_unit_if.sv
// ============================================================================
//  Module      : mul_modular_unit_if
//  Description : Operand / result bundle between the coprocessor controller
//                (master) and the modular multiplier (slave).
//  Ports       : a_i, b_i, p_i     - multiplicand, multiplier, modulus
//                mul_start_i       - start request
//                result_o          - product mod p
//                finish_o          - one-cycle completion pulse
//                busy_o            - operation in progress
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_modular_unit_if
    import ecc_instr::*;
#(
    parameter int WIDTH = EccWidth
);
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] p_i;
    logic             mul_start_i;
    logic [WIDTH-1:0] result_o;
    logic             finish_o;
    logic             busy_o;

    // Controller side: supplies operands, consumes the result.
    modport master (
        output a_i, b_i, p_i, mul_start_i,
        input  result_o, finish_o, busy_o
    );

    // Multiplier side.
    modport slave (
        input  a_i, b_i, p_i, mul_start_i,
        output result_o, finish_o, busy_o
    );

endinterface : mul_modular_unit_if

`default_nettype wire

// File: rtl/mod_dbl_add_step.sv
// ============================================================================
//  Module      : mod_dbl_add_step
//  Description : One iteration of the MSB-first interleaved modular multiply:
//                r' = 2r mod p, then r' = (r' + a) mod p when bit_i is set.
//                Purely combinational, WIDTH+1-bit internal arithmetic.
//  Ports       : r_i   - current accumulator (WIDTH+1 bits)
//                a_i   - multiplicand
//                p_i   - modulus
//                bit_i - current multiplier bit
//                r_o   - next accumulator (WIDTH+1 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_dbl_add_step
    import ecc_instr::*;
#(
    parameter int WIDTH = EccWidth
) (
    input  wire logic [WIDTH:0]   r_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] p_i,
    input  wire logic             bit_i,
    output logic      [WIDTH:0]   r_o
);

    logic [WIDTH:0] w_p_ext;
    logic [WIDTH:0] w_dbl;
    logic [WIDTH:0] w_red1;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_red2;
    logic           w_p_small;

    assign w_p_ext   = {1'b0, p_i};
    // A modulus of 0 or 1 would otherwise let the accumulator grow unreduced
    // (p = 0 never subtracts); pin it to zero so the result is defined.
    assign w_p_small = (p_i < WIDTH'(2));

    always_comb begin
        // With r < p the doubled value fits WIDTH+1 bits.
        w_dbl  = r_i << 1;
        w_red1 = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;

        w_sum  = w_red1 + {1'b0, a_i};
        if (bit_i) begin
            w_red2 = (w_sum >= w_p_ext) ? (w_sum - w_p_ext) : w_sum;
        end else begin
            w_red2 = w_red1;
        end

        r_o = w_p_small ? '0 : w_red2;
    end

endmodule : mod_dbl_add_step

`default_nettype wire

// File: rtl/mul_modular_unit.sv
// ============================================================================
//  Module      : mul_modular_unit
//  Description : Sequential interleaved modular multiplier, result =
//                (a * b) mod p, one multiplier bit per cycle, MSB first.
//                WIDTH cycles from the accepting edge to the finish pulse;
//                a start seen in DONE chains straight into the next run.
//  Ports       : clk_i - clock, rising edge
//                rst_i - asynchronous active-high reset
//                bus   - mul_modular_unit_if slave (operands, start,
//                        result, finish, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_modular_unit
    import ecc_instr::*;
#(
    parameter int WIDTH = EccWidth
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    mul_modular_unit_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;        // shifted left each step; MSB is the live bit
    logic [WIDTH-1:0] p_q;
    logic [WIDTH:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [WIDTH:0]   w_acc_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_last   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.mul_start_i) begin
                    w_accept = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (cnt_q == C_LAST_STEP) begin
                    w_last  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath iteration
    // ------------------------------------------------------------------
    mod_dbl_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i   (acc_q),
        .a_i   (a_q),
        .p_i   (p_q),
        .bit_i (b_q[WIDTH-1]),
        .r_o   (w_acc_next)
    );

    // ------------------------------------------------------------------
    // Operand, accumulator, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (w_accept) begin
                a_q   <= bus.a_i;
                b_q   <= bus.b_i;
                p_q   <= bus.p_i;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (w_step) begin
                acc_q <= w_acc_next;
                b_q   <= b_q << 1;
                cnt_q <= cnt_q + CNT_W'(1);
                if (w_last) begin
                    result_q <= w_acc_next[WIDTH-1:0];
                end
            end
        end
    end

    // Outputs decode directly from registered state, so they change only
    // on clock edges (or immediately on reset).
    assign bus.result_o = result_q;
    assign bus.finish_o = (state_q == DONE);
    assign bus.busy_o   = (state_q == RUN);

endmodule : mul_modular_unit

`default_nettype wire

// File: tb/tb_mul_modular_unit.sv
// ============================================================================
//  Module      : tb_mul_modular_unit
//  Description : Self-checking bench for mul_modular_unit: directed vectors,
//                randomized operands against an arithmetic reference,
//                ignored mid-run starts, back-to-back chaining and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_modular_unit;
    import ecc_instr::*;

    localparam int WIDTH   = EccWidth;
    localparam int C_LIMIT = 200;

    logic clk;
    logic rst;

    int n_checks;
    int n_fails;

    mul_modular_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_modular_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product via 128-bit arithmetic, reduced by p.
    function automatic logic [63:0] ref_mulmod(input logic [63:0] a, input logic [63:0] b,
                                               input logic [63:0] p);
        logic [127:0] prod;
        logic [127:0] rem;
        if (p < 64'd2) return 64'd0;
        prod = {64'd0, a} * {64'd0, b};
        rem  = prod % {64'd0, p};
        return rem[63:0];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] p);
        bus.a_i         = a;
        bus.b_i         = b;
        bus.p_i         = p;
        bus.mul_start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mul_start_i = 1'b0;
        bus.a_i         = rand64();   // operands must not matter after acceptance
        bus.b_i         = rand64();
        bus.p_i         = rand64();
    endtask

    // Counts negedges after the accepting edge until finish_o is seen.
    // noise_at > 0 pulses a start with junk operands at that cycle.
    task automatic wait_finish(input int noise_at, output int cycles, output int busy_n);
        cycles = 0;
        busy_n = 0;
        while (!bus.finish_o && cycles < C_LIMIT) begin
            if (bus.busy_o) busy_n++;
            @(negedge clk);
            cycles++;
            if (noise_at > 0 && cycles == noise_at) begin
                bus.a_i         = rand64();
                bus.b_i         = rand64();
                bus.p_i         = rand64() | 64'd3;
                bus.mul_start_i = 1'b1;
            end else if (noise_at > 0 && cycles == noise_at + 1) begin
                bus.mul_start_i = 1'b0;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] p, input logic [63:0] exp, input int noise_at);
        int cyc;
        int bsy;
        start_op(a, b, p);
        wait_finish(noise_at, cyc, bsy);
        check({tag, " latency"}, 64'(cyc), 64'(WIDTH));
        check({tag, " busy_cycles"}, 64'(bsy), 64'(WIDTH));
        check({tag, " result"}, bus.result_o, exp);
    endtask

    // One negedge after a finish with no restart: pulse must have ended.
    task automatic settle(input string tag, input logic [63:0] exp);
        @(negedge clk);
        check({tag, " finish_drop"}, 64'(bus.finish_o), 64'd0);
        check({tag, " idle_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, " result_hold"}, bus.result_o, exp);
    endtask

    localparam logic [63:0] C_P64 = 64'hFFFF_FFFF_FFFF_FFC5;

    initial begin
        logic [63:0] a, b, p, e;
        int fin_n;

        n_checks        = 0;
        n_fails         = 0;
        rst             = 1'b1;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.p_i         = '0;
        bus.mul_start_i = 1'b0;

        repeat (3) @(negedge clk);
        check("reset result", bus.result_o, 64'd0);
        check("reset finish", 64'(bus.finish_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        do_op("small", 64'd3, 64'd5, 64'd7, 64'd1, 0);
        settle("small", 64'd1);
        do_op("pm1sq", C_P64 - 64'd1, C_P64 - 64'd1, C_P64, 64'd1, 0);
        settle("pm1sq", 64'd1);
        do_op("pow32", 64'h1_0000_0000, 64'h1_0000_0000, C_P64, 64'd59, 0);
        settle("pow32", 64'd59);
        do_op("a_zero", 64'd0, 64'd12, 64'd13, 64'd0, 0);
        settle("a_zero", 64'd0);
        do_op("p_one", 64'd0, 64'd0, 64'd1, 64'd0, 0);
        settle("p_one", 64'd0);
        do_op("p_zero", 64'd5, 64'd7, 64'd0, 64'd0, 0);
        settle("p_zero", 64'd0);

        // Start during RUN must be ignored
        do_op("ignore", 64'd123456789, 64'd987654321, C_P64,
              ref_mulmod(64'd123456789, 64'd987654321, C_P64), 10);
        settle("ignore", ref_mulmod(64'd123456789, 64'd987654321, C_P64));

        // Back-to-back: second start issued while finish_o is high (DONE)
        do_op("chain1", 64'd9, 64'd10, 64'd97, 64'd90 % 64'd97, 0);
        do_op("chain2", 64'd50, 64'd60, 64'd97, (64'd3000) % 64'd97, 0);
        settle("chain2", (64'd3000) % 64'd97);

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) p = 64'($urandom_range(1000, 2));
            else            p = rand64();
            if (p < 64'd2) p = 64'd2;
            a = rand64() % p;
            b = rand64() % p;
            e = ref_mulmod(a, b, p);
            do_op($sformatf("rand%0d", i), a, b, p, e, 0);
            if (i % 2 == 1) settle($sformatf("rand%0d", i), e);
        end
        @(negedge clk);

        // Reset in the middle of a run
        start_op(C_P64 - 64'd2, C_P64 - 64'd3, C_P64);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(bus.busy_o), 64'd0);
        check("abort finish", 64'(bus.finish_o), 64'd0);
        check("abort result", bus.result_o, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        fin_n = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.finish_o || bus.busy_o) fin_n++;
        end
        check("abort no_finish", 64'(fin_n), 64'd0);
        do_op("post_reset", 64'd4, 64'd6, 64'd11, 64'd2, 0);
        settle("post_reset", 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mul_modular_unit

`default_nettype wire
